ifu_fetch: RTL and testbench



---
 rtl/ifu_fetch_pkg.sv | 18 +
 rtl/ifu_fetch_if.sv | 30 +++
 rtl/ifu_next_pc.sv | 21 ++
 rtl/ifu_fetch.sv | 93 +++++++++
 tb/tb_ifu_fetch.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared fetch-state encoding and control-flow constants
// Ports: none; imported by ifu_fetch, ifu_next_pc and the execute unit.
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC   = 32'h8000_0000;
  localparam int          INST_BYTES = 4;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

endpackage

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - fetch unit handshake bundle (imem request/response, inst out, redirect in)
// Ports: none. Modport master = fetch unit side, slave = memory/decode/execute side.
interface ifu_fetch_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  jump;
  logic [DATA_WIDTH-1:0] upc;
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] inst;
  logic [DATA_WIDTH-1:0] pc;
  logic                  fetch_err;

  modport master (
    input  jump, upc, imem_req_ready, imem_rsp_valid, imem_rdata, inst_ready,
    output imem_req_valid, imem_addr, inst_valid, inst, pc, fetch_err
  );

  modport slave (
    output jump, upc, imem_req_ready, imem_rsp_valid, imem_rdata, inst_ready,
    input  imem_req_valid, imem_addr, inst_valid, inst, pc, fetch_err
  );

endinterface

// File: rtl/ifu_next_pc.sv
// rtl/ifu_next_pc.sv - next fetch address select (sequential vs redirect) and misalignment detect
// Ports: pc (held instruction address), jump/upc (redirect request),
//        next_pc (address of the following fetch), misaligned (redirect target not word aligned).
module ifu_next_pc
  import ifu_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  jump,
  input  logic [DATA_WIDTH-1:0] upc,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  misaligned
);

  // Sequential increment wraps naturally at the top of the address space.
  assign next_pc    = jump ? upc : pc + DATA_WIDTH'(INST_BYTES);
  // Bit 0 is cleared upstream for jalr, so any set low bit here is a real fault.
  assign misaligned = jump && (upc[1:0] != 2'b00);

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - single-outstanding instruction fetch FSM holding inst/pc for decode
// Ports: clk, rst (sync active-high), bus (ifu_fetch_if.master): imem request/response,
//        inst/pc/inst_valid/inst_ready to decode, jump/upc from execute, sticky fetch_err.
module ifu_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = ifu_fetch_pkg::RESET_PC
) (
  input  logic       clk,
  input  logic       rst,
  ifu_fetch_if.master bus
);

  import ifu_fetch_pkg::*;

  fetch_state_e          state;
  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] inst_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic                  req_valid_q;
  logic                  inst_valid_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  misaligned;

  ifu_next_pc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_next_pc (
    .pc        (pc_q),
    .jump      (bus.jump),
    .upc       (bus.upc),
    .next_pc   (next_pc),
    .misaligned(misaligned)
  );

  // req_valid_q / inst_valid_q mirror S_REQ / S_HOLD and are updated together with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_REQ;
      fetch_pc     <= RESET_PC;
      inst_q       <= '0;
      pc_q         <= RESET_PC;
      err_q        <= 1'b0;
      req_valid_q  <= 1'b1;
      inst_valid_q <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (bus.imem_req_ready) begin
            state       <= S_WAIT;
            req_valid_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            inst_q       <= bus.imem_rdata;
            pc_q         <= fetch_pc;
            state        <= S_HOLD;
            inst_valid_q <= 1'b1;
          end
        end
        S_HOLD: begin
          // jump/upc are only meaningful in the cycle the held instruction retires.
          if (bus.inst_ready) begin
            inst_valid_q <= 1'b0;
            fetch_pc     <= next_pc;
            if (misaligned) begin
              state <= S_ERR;
              err_q <= 1'b1;
            end else begin
              state       <= S_REQ;
              req_valid_q <= 1'b1;
            end
          end
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: begin
          state <= S_ERR;
        end
      endcase
    end
  end

  // Handshake valids are masked while rst is high so nothing is offered in the reset cycle.
  assign bus.imem_req_valid = req_valid_q & ~rst;
  assign bus.imem_addr      = fetch_pc;
  assign bus.inst_valid     = inst_valid_q & ~rst;
  assign bus.inst           = inst_q;
  assign bus.pc             = pc_q;
  assign bus.fetch_err      = err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch against a transaction-level model
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] m_fetch;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        m_err;

  ifu_fetch_if #(.DATA_WIDTH(32)) bus ();

  ifu_fetch #(.DATA_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rdata     = '0;
    bus.inst_ready     = 1'b0;
    bus.jump           = 1'b0;
    bus.upc            = '0;
  endtask

  task automatic do_reset(input logic rsp_with_reset);
    rst = 1'b1;
    quiet_inputs();
    bus.imem_rsp_valid = rsp_with_reset;
    bus.imem_rdata     = 32'hDEAD_BEEF;
    #1;
    chk1("rst_req_valid", bus.imem_req_valid, 1'b0);
    chk1("rst_inst_valid", bus.inst_valid, 1'b0);
    next_cycle();
    rst = 1'b0;
    quiet_inputs();
    m_fetch = RST_PC;
    m_pc    = RST_PC;
    m_inst  = '0;
    m_err   = 1'b0;
    #1;
    chk32("post_rst_inst", bus.inst, m_inst);
    chk32("post_rst_pc", bus.pc, m_pc);
    chk1("post_rst_err", bus.fetch_err, 1'b0);
  endtask

  // Offer the request; memory stalls req_dly cycles before accepting.
  task automatic issue(input int req_dly);
    for (int i = 0; i < req_dly; i++) begin
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'($urandom_range(0, 1));
      bus.jump           = 1'($urandom_range(0, 1));
      bus.upc            = $urandom;
      #1;
      chk1("req_valid_stall", bus.imem_req_valid, 1'b1);
      chk32("req_addr_stall", bus.imem_addr, m_fetch);
      chk1("inst_valid_in_req", bus.inst_valid, 1'b0);
      next_cycle();
    end
    quiet_inputs();
    bus.imem_req_ready = 1'b1;
    #1;
    chk1("req_valid", bus.imem_req_valid, 1'b1);
    chk32("req_addr", bus.imem_addr, m_fetch);
    next_cycle();
    bus.imem_req_ready = 1'b0;
  endtask

  // Memory answers after rsp_dly idle cycles.
  task automatic respond(input int rsp_dly, input logic [31:0] rd);
    for (int i = 0; i < rsp_dly; i++) begin
      bus.imem_req_ready = 1'($urandom_range(0, 1));
      bus.imem_rsp_valid = 1'b0;
      #1;
      chk1("no_dup_req", bus.imem_req_valid, 1'b0);
      chk1("inst_valid_in_wait", bus.inst_valid, 1'b0);
      chk32("inst_before_rsp", bus.inst, m_inst);
      next_cycle();
    end
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rdata     = rd;
    #1;
    chk1("no_req_at_rsp", bus.imem_req_valid, 1'b0);
    next_cycle();
    bus.imem_rsp_valid = 1'b0;
    m_inst = rd;
    m_pc   = m_fetch;
  endtask

  // Downstream stalls hold_dly cycles with a noisy jump/upc, then retires with (j, u).
  task automatic retire(input int hold_dly, input logic j, input logic [31:0] u);
    for (int i = 0; i < hold_dly; i++) begin
      bus.inst_ready     = 1'b0;
      bus.jump           = 1'($urandom_range(0, 1));
      bus.upc            = $urandom;
      bus.imem_rsp_valid = 1'($urandom_range(0, 1));
      bus.imem_rdata     = $urandom;
      #1;
      chk1("hold_inst_valid", bus.inst_valid, 1'b1);
      chk32("hold_inst", bus.inst, m_inst);
      chk32("hold_pc", bus.pc, m_pc);
      chk1("hold_no_req", bus.imem_req_valid, 1'b0);
      next_cycle();
    end
    quiet_inputs();
    bus.inst_ready = 1'b1;
    bus.jump       = j;
    bus.upc        = u;
    #1;
    chk1("retire_inst_valid", bus.inst_valid, 1'b1);
    chk32("retire_inst", bus.inst, m_inst);
    chk32("retire_pc", bus.pc, m_pc);
    next_cycle();
    quiet_inputs();
    if (j && (u % 4 != 0)) m_err = 1'b1;
    else                   m_fetch = j ? u : m_pc + 32'd4;
    #1;
    chk1("fetch_err", bus.fetch_err, m_err);
    if (m_err) begin
      for (int i = 0; i < 3; i++) begin
        bus.imem_req_ready = 1'($urandom_range(0, 1));
        bus.imem_rsp_valid = 1'($urandom_range(0, 1));
        bus.inst_ready     = 1'($urandom_range(0, 1));
        #1;
        chk1("err_no_req", bus.imem_req_valid, 1'b0);
        chk1("err_no_inst", bus.inst_valid, 1'b0);
        chk1("err_sticky", bus.fetch_err, 1'b1);
        chk32("err_pc", bus.pc, m_pc);
        next_cycle();
      end
      quiet_inputs();
    end
  endtask

  task automatic fetch(input int rq, input int rs, input int hd, input logic j,
                       input logic [31:0] u, input logic [31:0] rd);
    issue(rq);
    respond(rs, rd);
    retire(hd, j, u);
  endtask

  initial begin
    quiet_inputs();
    m_fetch = RST_PC;
    m_pc    = RST_PC;
    m_inst  = '0;
    m_err   = 1'b0;
    next_cycle();

    // Reset and zero-wait fetch at RESET_PC, then sequential next address.
    do_reset(1'b0);
    fetch(0, 0, 0, 1'b0, 32'h0, 32'h0000_0013);
    chk32("seq_next_addr", bus.imem_addr, 32'h8000_0004);

    // Stalled acceptance and delayed response.
    fetch(5, 3, 0, 1'b0, 32'h0, 32'h1234_5678);

    // Long hold with jump toggling; only the retire-cycle redirect counts.
    fetch(0, 0, 4, 1'b0, 32'h0, 32'hCAFE_0001);

    // Jump into 8000_0010, then taken jump to 8000_0100.
    fetch(0, 0, 0, 1'b1, 32'h8000_0010, 32'h0000_0001);
    fetch(0, 0, 0, 1'b1, 32'h8000_0100, 32'h0000_0002);
    chk32("jump_target", bus.imem_addr, 32'h8000_0100);
    fetch(0, 0, 0, 1'b1, 32'h8000_0010, 32'h0000_0003);
    fetch(0, 0, 0, 1'b0, 32'h0, 32'h0000_0004);
    chk32("no_jump_seq", bus.imem_addr, 32'h8000_0014);

    // Wrap-around at the top of the address space.
    fetch(1, 1, 1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0005);
    fetch(0, 2, 0, 1'b0, 32'h0, 32'h0000_0006);
    chk32("wrap_addr", bus.imem_addr, 32'h0000_0000);

    // Misaligned redirect traps until reset.
    fetch(0, 0, 0, 1'b0, 32'h0, 32'h0000_0007);
    fetch(0, 0, 0, 1'b1, 32'h8000_0102, 32'h0000_0008);
    do_reset(1'b0);
    chk1("after_err_req", bus.imem_req_valid, 1'b1);
    chk32("after_err_addr", bus.imem_addr, RST_PC);

    // Reset in S_WAIT coinciding with the response drops that response.
    fetch(0, 0, 0, 1'b0, 32'h0, 32'h5555_AAAA);
    issue(0);
    do_reset(1'b1);
    chk32("rst_wait_inst", bus.inst, 32'h0);
    chk1("rst_wait_req", bus.imem_req_valid, 1'b1);
    chk32("rst_wait_addr", bus.imem_addr, RST_PC);

    // Randomized traffic with aligned redirects.
    for (int n = 0; n < 40; n++) begin
      logic        j;
      logic [31:0] u;
      j = 1'($urandom_range(0, 1));
      u = $urandom & 32'hFFFF_FFFC;
      fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            j, u, $urandom);
    end
    chk32("final_addr", bus.imem_addr, m_fetch);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
